// File: rtl/movegen_pkg.sv
// Shared types and constants for the move-generation sequencer: direction codes,
// sequencer states and the serialised move record.
package movegen_pkg;

    typedef enum logic [3:0] {
        DIR_U   = 4'd0,  DIR_D   = 4'd1,  DIR_L   = 4'd2,  DIR_R   = 4'd3,
        DIR_UL  = 4'd4,  DIR_UR  = 4'd5,  DIR_DL  = 4'd6,  DIR_DR  = 4'd7,
        DIR_UUL = 4'd8,  DIR_UUR = 4'd9,  DIR_LLU = 4'd10, DIR_RRU = 4'd11,
        DIR_DDL = 4'd12, DIR_DDR = 4'd13, DIR_LLD = 4'd14, DIR_RRD = 4'd15
    } dir_e;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_PROP, S_FETCH, S_SEL, S_EMIT, S_DONE
    } state_e;

    typedef struct packed {
        logic [5:0] from;
        logic [5:0] to;
        logic [3:0] dir;
    } move_t;

    localparam logic [5:0] EMPTY_PIECE = 6'b000000;
    localparam logic [5:0] SQ_LAST     = 6'd63;

    function automatic logic [15:0] dir_bit(input logic [3:0] d);
        return 16'h0001 << d;
    endfunction

endpackage

// File: rtl/dir_prio_enc.sv
// Lowest-set-bit encoder over the 16 direction flags of one square.
module dir_prio_enc (
    input  logic [15:0] req,
    output logic [3:0]  dir,
    output logic        any
);

    // Walk from the top so the lowest set bit is the last one written.
    always_comb begin
        dir = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) dir = 4'(i);
        end
    end

    assign any = |req;

endmodule

// File: rtl/movegen_sequencer.sv
// Drives one move-generation pass of the 8x8 transceiver array: clear, load from
// board RAM, wait for ray propagation, then serialise every hit as a move.
module movegen_sequencer
    import movegen_pkg::*;
#(
    parameter int PROP_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] move_count,
    output logic [5:0]       brd_addr,
    input  logic [5:0]       brd_data,
    output logic             arr_clr,
    output logic             load_en,
    output logic [5:0]       load_addr,
    output logic [5:0]       load_piece,
    output logic [5:0]       scan_sq,
    input  logic [15:0]      scan_hits,
    output logic [3:0]       scan_dir,
    input  logic [5:0]       scan_from,
    output logic             mv_valid,
    input  logic             mv_ready,
    output logic [5:0]       mv_from,
    output logic [5:0]       mv_to,
    output logic [3:0]       mv_dir
);

    // Shared timer: counts 0..64 in LOAD and 0..PROP_CYCLES-1 in PROP.
    localparam int TMR_W = ($clog2(PROP_CYCLES + 1) > 7) ? $clog2(PROP_CYCLES + 1) : 7;

    state_e             state, state_nx;
    logic [TMR_W-1:0]   tmr, tmr_nx;
    logic [15:0]        pending, pending_nx, pending_clr;
    move_t              mv_q, mv_nx;
    logic               busy_nx, done_nx, arr_clr_nx, load_en_nx, mv_valid_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic [5:0]         brd_addr_nx, load_addr_nx, load_piece_nx, scan_sq_nx;
    logic [3:0]         scan_dir_nx;
    logic [15:0]        enc_req;
    logic [3:0]         enc_dir;
    logic               enc_any;

    // FETCH encodes the fresh hit vector; EMIT looks at what remains after this move.
    assign pending_clr = pending & ~dir_bit(scan_dir);
    assign enc_req     = (state == S_FETCH) ? scan_hits : pending_clr;

    dir_prio_enc u_enc (
        .req (enc_req),
        .dir (enc_dir),
        .any (enc_any)
    );

    assign mv_from = mv_q.from;
    assign mv_to   = mv_q.to;
    assign mv_dir  = mv_q.dir;

    always_comb begin
        state_nx      = state;
        tmr_nx        = tmr;
        pending_nx    = pending;
        mv_nx         = mv_q;
        done_nx       = 1'b0;
        arr_clr_nx    = 1'b0;
        load_en_nx    = 1'b0;
        mv_valid_nx   = 1'b0;
        cnt_nx        = move_count;
        brd_addr_nx   = brd_addr;
        load_addr_nx  = load_addr;
        load_piece_nx = load_piece;
        scan_sq_nx    = scan_sq;
        scan_dir_nx   = scan_dir;

        if (abort && state != S_IDLE) begin
            // Abort wins over everything, including a handshake in the same cycle.
            state_nx   = S_IDLE;
            arr_clr_nx = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nx    = S_CLEAR;
                        cnt_nx      = '0;
                        arr_clr_nx  = 1'b1;
                        brd_addr_nx = 6'd0;
                    end
                end
                S_CLEAR: begin
                    state_nx    = S_LOAD;
                    tmr_nx      = '0;
                    brd_addr_nx = 6'd1;
                end
                S_LOAD: begin
                    // brd_data now holds the square read two cycles ago, i.e. square tmr.
                    if (tmr == TMR_W'(64)) begin
                        state_nx = S_PROP;
                        tmr_nx   = '0;
                    end else begin
                        load_en_nx    = 1'b1;
                        load_addr_nx  = tmr[5:0];
                        load_piece_nx = brd_data;
                        tmr_nx        = tmr + TMR_W'(1);
                        if (brd_addr != SQ_LAST) brd_addr_nx = brd_addr + 6'd1;
                    end
                end
                S_PROP: begin
                    if (tmr == TMR_W'(PROP_CYCLES - 1)) begin
                        state_nx   = S_FETCH;
                        scan_sq_nx = 6'd0;
                    end else begin
                        tmr_nx = tmr + TMR_W'(1);
                    end
                end
                S_FETCH: begin
                    pending_nx = scan_hits;
                    if (enc_any) begin
                        state_nx    = S_SEL;
                        scan_dir_nx = enc_dir;
                    end else if (scan_sq == SQ_LAST) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                    end else begin
                        scan_sq_nx = scan_sq + 6'd1;
                    end
                end
                S_SEL: begin
                    mv_nx       = '{from: scan_from, to: scan_sq, dir: scan_dir};
                    mv_valid_nx = 1'b1;
                    state_nx    = S_EMIT;
                end
                S_EMIT: begin
                    mv_valid_nx = 1'b1;
                    if (mv_ready) begin
                        mv_valid_nx = 1'b0;
                        pending_nx  = pending_clr;
                        cnt_nx      = (&move_count) ? move_count : move_count + CNT_W'(1);
                        if (enc_any) begin
                            state_nx    = S_SEL;
                            scan_dir_nx = enc_dir;
                        end else if (scan_sq == SQ_LAST) begin
                            state_nx = S_DONE;
                            done_nx  = 1'b1;
                        end else begin
                            state_nx   = S_FETCH;
                            scan_sq_nx = scan_sq + 6'd1;
                        end
                    end
                end
                S_DONE: state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end

        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tmr        <= '0;
            pending    <= '0;
            mv_q       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            move_count <= '0;
            brd_addr   <= 6'd0;
            arr_clr    <= 1'b0;
            load_en    <= 1'b0;
            load_addr  <= 6'd0;
            load_piece <= EMPTY_PIECE;
            scan_sq    <= 6'd0;
            scan_dir   <= 4'd0;
            mv_valid   <= 1'b0;
        end else begin
            state      <= state_nx;
            tmr        <= tmr_nx;
            pending    <= pending_nx;
            mv_q       <= mv_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            move_count <= cnt_nx;
            brd_addr   <= brd_addr_nx;
            arr_clr    <= arr_clr_nx;
            load_en    <= load_en_nx;
            load_addr  <= load_addr_nx;
            load_piece <= load_piece_nx;
            scan_sq    <= scan_sq_nx;
            scan_dir   <= scan_dir_nx;
            mv_valid   <= mv_valid_nx;
        end
    end

endmodule

// File: tb/tb_movegen_sequencer.sv
// Scoreboard bench for movegen_sequencer: a board RAM model and a table-driven
// array model feed the DUT; a monitor pops expected moves on every handshake.
module tb_movegen_sequencer;
    import movegen_pkg::*;

    localparam int PROP = 8;
    localparam int CW   = 8;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, mv_ready = 1'b1;
    logic          busy, done, arr_clr, load_en, mv_valid;
    logic [CW-1:0] move_count;
    logic [5:0]    brd_addr, brd_data, load_addr, load_piece, scan_sq, scan_from, mv_from, mv_to;
    logic [15:0]   scan_hits;
    logic [3:0]    scan_dir, mv_dir;

    logic [5:0]    ram [64];
    logic [15:0]   hits_tab [64];
    logic [5:0]    from_tab [64][16];
    move_t         exp_q [$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int base = 0, rel, n_clr, clr_rel, n_load, n_done, done_rel, n_vld, n_stall;
    logic  stall_prev, hs_prev;
    move_t held, popped;

    movegen_sequencer #(.PROP_CYCLES(PROP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .move_count(move_count), .brd_addr(brd_addr), .brd_data(brd_data), .arr_clr(arr_clr),
        .load_en(load_en), .load_addr(load_addr), .load_piece(load_piece), .scan_sq(scan_sq),
        .scan_hits(scan_hits), .scan_dir(scan_dir), .scan_from(scan_from), .mv_valid(mv_valid),
        .mv_ready(mv_ready), .mv_from(mv_from), .mv_to(mv_to), .mv_dir(mv_dir)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) brd_data <= ram[brd_addr];

    assign scan_hits = hits_tab[scan_sq];
    assign scan_from = from_tab[scan_sq][scan_dir];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 64'({busy, done, move_count, brd_addr, arr_clr, load_en, load_addr, load_piece,
                       scan_sq, scan_dir, mv_valid, mv_from, mv_to, mv_dir}), 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tabs();
        for (int s = 0; s < 64; s++) begin
            hits_tab[s] = 16'h0000;
            for (int d = 0; d < 16; d++) from_tab[s][d] = 6'((s * 3 + d * 7) % 64);
        end
    endtask

    task automatic push_move(input int f, input int t, input int d);
        exp_q.push_back('{from: 6'(f), to: 6'(t), dir: 4'(d)});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns just after the monitor has sampled the DONE cycle.
    task automatic wait_done(input string name, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end else begin
            @(negedge clk);
            #1;
        end
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        stall_prev = 1'b0;
        hs_prev    = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                hs_prev    = 1'b0;
            end else begin
                if (start && !busy) begin
                    base = cyc; n_clr = 0; n_load = 0; n_done = 0; n_vld = 0; n_stall = 0;
                    clr_rel = -1; done_rel = -1;
                end
                rel = cyc - base;
                if (arr_clr) begin n_clr++; clr_rel = rel; end
                if (load_en) begin
                    chk("load_addr", 64'(load_addr), 64'(n_load[5:0]));
                    chk("load_piece", 64'(load_piece), 64'(ram[n_load[5:0]]));
                    chk("load_cycle", 64'(rel), 64'(n_load + 3));
                    n_load++;
                end
                if (done) begin n_done++; done_rel = rel; end
                if (mv_valid) n_vld++;
                if (hs_prev) chk("valid_drop_after_hs", 64'(mv_valid), 64'd0);
                if (stall_prev) begin
                    chk("valid_hold", 64'(mv_valid), 64'd1);
                    chk("payload_hold", 64'({mv_from, mv_to, mv_dir}), 64'(held));
                end
                if (mv_valid && mv_ready && !abort) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_move: got %0d/%0d/%0d expected none", mv_from, mv_to, mv_dir);
                    end else begin
                        popped = exp_q.pop_front();
                        chk("mv_from", 64'(mv_from), 64'(popped.from));
                        chk("mv_to", 64'(mv_to), 64'(popped.to));
                        chk("mv_dir", 64'(mv_dir), 64'(popped.dir));
                    end
                end
                if (mv_valid && !mv_ready && !abort) n_stall++;
                hs_prev    = mv_valid && mv_ready && !abort;
                stall_prev = mv_valid && !mv_ready && !abort;
                held       = '{from: mv_from, to: mv_to, dir: mv_dir};
            end
        end
    end

    initial begin : stimulus
        bit ok;
        int seen;
        logic prev_v;

        for (int i = 0; i < 64; i++) ram[i] = 6'((i * 5 + 3) % 64);
        clear_tabs();

        // Reset state
        repeat (2) tick();
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        tick();

        // 1: no hits -> pass timing, full load, zero moves
        pulse_start();
        wait_done("t1_done", 400);
        chk("t1_clr_count", 64'(n_clr), 64'd1);
        chk("t1_clr_cycle", 64'(clr_rel), 64'd1);
        chk("t1_load_count", 64'(n_load), 64'd64);
        chk("t1_done_cycle", 64'(done_rel), 64'd139);
        chk("t1_move_count", 64'(move_count), 64'd0);
        chk("t1_valid_cycles", 64'(n_vld), 64'd0);
        tick();
        chk("t1_done_pulse", 64'({done, busy}), 64'd0);

        // 2: sq 20 hits U and UL
        hits_tab[20] = 16'h0011;
        from_tab[20][0] = 6'd12;
        from_tab[20][4] = 6'd36;
        push_move(12, 20, 0);
        push_move(36, 20, 4);
        pulse_start();
        wait_done("t2_done", 400);
        chk("t2_move_count", 64'(move_count), 64'd2);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t2_done_count", 64'(n_done), 64'd1);
        tick();

        // 3: same with a 5-cycle stall; hit vector withdrawn mid-emit must not matter
        push_move(12, 20, 0);
        push_move(36, 20, 4);
        mv_ready = 1'b0;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (mv_valid) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL t3_valid: mv_valid not seen within 300 cycles");
        end
        hits_tab[20] = 16'h0000;
        repeat (5) tick();
        mv_ready = 1'b1;
        wait_done("t3_done", 400);
        chk("t3_stall_cycles", 64'(n_stall), 64'd5);
        chk("t3_move_count", 64'(move_count), 64'd2);
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        hits_tab[20] = 16'h0011;
        tick();

        // 4: abort on the third EMIT, coinciding with a handshake
        hits_tab[30] = 16'h0100;
        from_tab[30][8] = 6'd47;
        push_move(12, 20, 0);
        push_move(36, 20, 4);
        pulse_start();
        seen = 0;
        prev_v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (mv_valid && !prev_v) seen++;
            prev_v = mv_valid;
            if (seen == 3) break;
            tick();
        end
        chk("t4_third_emit_seen", 64'(seen), 64'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_idle_after_abort", 64'({busy, mv_valid, done}), 64'd0);
        chk("t4_arr_clr", 64'(arr_clr), 64'd1);
        chk("t4_move_count", 64'(move_count), 64'd2);
        tick();
        chk("t4_arr_clr_drop", 64'(arr_clr), 64'd0);
        repeat (5) tick();
        chk("t4_no_done", 64'(n_done), 64'd0);
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("t4_count_hold", 64'(move_count), 64'd2);
        clear_tabs();

        // 5: every square full -> 1024 moves, counter saturates
        for (int s = 0; s < 64; s++) begin
            hits_tab[s] = 16'hFFFF;
            for (int d = 0; d < 16; d++) push_move(int'(from_tab[s][d]), s, d);
        end
        pulse_start();
        wait_done("t5_done", 5000);
        chk("t5_move_count_sat", 64'(move_count), 64'd255);
        chk("t5_done_count", 64'(n_done), 64'd1);
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        clear_tabs();
        tick();

        // 6: start held through the pass, then reset during the next LOAD
        start = 1'b1;
        tick();
        wait_done("t6_done", 400);
        chk("t6_single_clear", 64'(n_clr), 64'd1);
        chk("t6_done_cycle", 64'(done_rel), 64'd139);
        tick();
        chk("t6_idle_gap", 64'(busy), 64'd0);
        tick();
        chk("t6_restart", 64'({busy, arr_clr}), 64'b11);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (load_en) begin ok = 1'b1; break; end
        end
        chk("t6_in_load", 64'(ok), 64'd1);
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t6_async_reset");
        tick();
        rst_n = 1'b1;
        tick();
        chk_all_zero("t6_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
